// File: rtl/matriz_escalar_seq_if.sv
// ----------------------------------------------------------------------------
// matriz_escalar_seq_if
// Request/operand/result bundle for the scalar-by-matrix sequencer.
//   start, abort          : operation request and cancel
//   data_escalar          : signed 8-bit scalar
//   matriz_a              : N signed 8-bit elements, element k at [8k+7:8k]
//   matriz_resultante     : registered result matrix, same packing
//   busy, done, ovf       : status (busy in LOAD/RUN, done pulse, sticky overflow)
// master drives requests/operands; slave is the sequencer.
// ----------------------------------------------------------------------------
interface matriz_escalar_seq_if #(
    parameter int N = 25
);
    logic             start;
    logic             abort;
    logic [7:0]       data_escalar;
    logic [8*N-1:0]   matriz_a;
    logic [8*N-1:0]   matriz_resultante;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, abort, data_escalar, matriz_a,
        input  matriz_resultante, busy, done, ovf
    );

    modport slave (
        input  start, abort, data_escalar, matriz_a,
        output matriz_resultante, busy, done, ovf
    );
endinterface

// File: rtl/matriz_escalar_seq.sv
// ----------------------------------------------------------------------------
// matriz_escalar_seq
// Multiplies a captured signed 8-bit scalar by N captured signed 8-bit matrix
// elements, one element per cycle through a single shared 8x8 multiplier.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : matriz_escalar_seq_if.slave (start/abort, operands, result, status)
// Build option: define MATRIZ_ESCALAR_SAT_EN to clamp out-of-range products to
// 127/-128; otherwise products wrap to their low 8 bits. ovf is identical in
// both builds.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// LOAD  | one-cycle settle after capture
// RUN   | element idx multiplied and written each cycle
// DONE  | one-cycle done pulse, then back to IDLE
// ----------------------------------------------------------------------------
module matriz_escalar_seq #(
    parameter int N = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    matriz_escalar_seq_if.slave   bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic [IDX_W-1:0]     idx;
    logic signed [7:0]    escalar_q;
    logic [8*N-1:0]       matriz_q;
    logic [8*N-1:0]       res_q;
    logic                 ovf_q;

    logic                 load_en;
    logic                 write_en;
    logic signed [7:0]    elem_a;
    logic signed [15:0]   prod;
    logic                 prod_ovf;
    logic [7:0]           prod_red;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // abort outranks the last-element transition to DONE
    always_comb begin
        state_nx = state;
        load_en  = 1'b0;
        write_en = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = LOAD;
                    load_en  = 1'b1;
                end
            end
            LOAD: state_nx = bus.abort ? IDLE : RUN;
            RUN: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                end else begin
                    write_en = 1'b1;
                    if (idx == IDX_W'(N - 1)) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign elem_a   = matriz_q[{idx, 3'b000} +: 8];
    assign prod     = escalar_q * elem_a;
    assign prod_ovf = (prod > 16'sd127) || (prod < -16'sd128);

`ifdef MATRIZ_ESCALAR_SAT_EN
    assign prod_red = prod_ovf ? (prod[15] ? 8'h80 : 8'h7F) : prod[7:0];
`else
    assign prod_red = prod[7:0];
`endif

    // An aborted RUN cycle writes nothing, so the result holds only finished elements.
    always_ff @(posedge clk) begin
        if (rst) begin
            escalar_q <= '0;
            matriz_q  <= '0;
            idx       <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (load_en) begin
                escalar_q <= bus.data_escalar;
                matriz_q  <= bus.matriz_a;
                idx       <= '0;
                ovf_q     <= 1'b0;
            end
            if (write_en) begin
                res_q[{idx, 3'b000} +: 8] <= prod_red;
                idx                       <= idx + IDX_W'(1);
                if (prod_ovf) ovf_q <= 1'b1;
            end
        end
    end

    assign bus.matriz_resultante = res_q;
    assign bus.ovf               = ovf_q;
    assign bus.busy              = (state == LOAD) || (state == RUN);
    assign bus.done              = (state == DONE);

endmodule

// File: tb/tb_matriz_escalar_seq.sv
module tb_matriz_escalar_seq;
    localparam int N = 25;
`ifdef MATRIZ_ESCALAR_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    matriz_escalar_seq_if #(.N(N)) bus_if ();

    matriz_escalar_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    // advance past the next rising edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue one start and watch 30 edges, reporting when done was seen
    task automatic run_op(input logic [7:0] esc, input logic [8*N-1:0] mat,
                          output int first_done, output int n_done);
        first_done = -1;
        n_done     = 0;
        bus_if.data_escalar = esc;
        bus_if.matriz_a     = mat;
        bus_if.start        = 1'b1;
        tick();
        bus_if.start        = 1'b0;
        bus_if.matriz_a     = '0;
        bus_if.data_escalar = 8'h00;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus_if.done) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (bus_if.matriz_resultante !== '0) begin
            errors++;
            $display("FAIL reset_result got %h want 0", bus_if.matriz_resultante);
        end
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus_if.busy);
        end
        checks++;
        if (bus_if.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", bus_if.done);
        end
        checks++;
        if (bus_if.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", bus_if.ovf);
        end
    endtask

    task automatic test_basic();
        logic [8*N-1:0] mat, exp;
        int first, cnt;
        for (int k = 0; k < N; k++) begin
            mat[8*k +: 8] = 8'd2;
            exp[8*k +: 8] = 8'd6;
        end
        run_op(8'd3, mat, first, cnt);
        checks++;
        if (first !== 26) begin
            errors++;
            $display("FAIL basic_latency got %0d want 26", first);
        end
        checks++;
        if (cnt !== 1) begin
            errors++;
            $display("FAIL basic_done_count got %0d want 1", cnt);
        end
        checks++;
        if (bus_if.matriz_resultante !== exp) begin
            errors++;
            $display("FAIL basic_result got %h want %h", bus_if.matriz_resultante, exp);
        end
        checks++;
        if (bus_if.ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_ovf got %b want 0", bus_if.ovf);
        end
    endtask

    task automatic test_overflow();
        logic [8*N-1:0] mat, exp;
        int first, cnt;
        for (int k = 0; k < N; k++) begin
            mat[8*k +: 8] = 8'd1;
            exp[8*k +: 8] = 8'd16;
        end
        mat[7:0] = 8'd10;
        exp[7:0] = SAT ? 8'h7F : 8'hA0;
        run_op(8'd16, mat, first, cnt);
        checks++;
        if (first !== 26 || cnt !== 1) begin
            errors++;
            $display("FAIL ovf_done got first=%0d count=%0d want 26/1", first, cnt);
        end
        checks++;
        if (bus_if.matriz_resultante !== exp) begin
            errors++;
            $display("FAIL ovf_result got %h want %h", bus_if.matriz_resultante, exp);
        end
        checks++;
        if (bus_if.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got %b want 1", bus_if.ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [8*N-1:0] mat, exp;
        int first, cnt;
        first = -1;
        cnt   = 0;
        for (int k = 0; k < N; k++) begin
            mat[8*k +: 8] = 8'(k);
            exp[8*k +: 8] = 8'(-k);
        end
        // start and abort together in IDLE: start must win
        bus_if.data_escalar = 8'hFF;
        bus_if.matriz_a     = mat;
        bus_if.start        = 1'b1;
        bus_if.abort        = 1'b1;
        tick();
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_over_abort busy got %b want 1", bus_if.busy);
        end
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (bus_if.done) begin
                cnt++;
                if (first < 0) first = k;
            end
            bus_if.start = (k == 0) || (k == 5) || (k == 26);
        end
        bus_if.start = 1'b0;
        checks++;
        if (first !== 26) begin
            errors++;
            $display("FAIL b2b_latency got %0d want 26", first);
        end
        checks++;
        if (cnt !== 1) begin
            errors++;
            $display("FAIL b2b_done_count got %0d want 1", cnt);
        end
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_after got %b want 0", bus_if.busy);
        end
        checks++;
        if (bus_if.matriz_resultante !== exp) begin
            errors++;
            $display("FAIL b2b_result got %h want %h", bus_if.matriz_resultante, exp);
        end
    endtask

    // relies on the -k result left by test_back_to_back
    task automatic test_abort();
        logic [8*N-1:0] mat, exp;
        int cnt;
        cnt = 0;
        for (int k = 0; k < N; k++) begin
            mat[8*k +: 8] = 8'd100;
            exp[8*k +: 8] = (k < 10) ? (SAT ? 8'h7F : 8'hC8) : 8'(-k);
        end
        bus_if.data_escalar = 8'd2;
        bus_if.matriz_a     = mat;
        bus_if.start        = 1'b1;
        tick();
        bus_if.start = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before got %b want 1", bus_if.busy);
        end
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy %b want 0", bus_if.busy);
        end
        for (int k = 0; k < 30; k++) begin
            if (bus_if.done) cnt++;
            tick();
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d pulses want 0", cnt);
        end
        checks++;
        if (bus_if.matriz_resultante !== exp) begin
            errors++;
            $display("FAIL abort_result got %h want %h", bus_if.matriz_resultante, exp);
        end
        checks++;
        if (bus_if.ovf !== 1'b1) begin
            errors++;
            $display("FAIL abort_ovf_kept got %b want 1", bus_if.ovf);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [8*N-1:0] mat, exp;
        int first, cnt;
        for (int k = 0; k < N; k++) begin
            mat[8*k +: 8] = 8'(k);
            exp[8*k +: 8] = 8'(2 * k);
        end
        mat[7:0] = 8'd100;
        bus_if.data_escalar = 8'd2;
        bus_if.matriz_a     = mat;
        bus_if.start        = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (bus_if.ovf !== 1'b1 || bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre got ovf=%b busy=%b want 1/1", bus_if.ovf, bus_if.busy);
        end
        rst          = 1'b1;
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        tick();
        rst          = 1'b0;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        checks++;
        if (bus_if.matriz_resultante !== '0 || bus_if.busy !== 1'b0 ||
            bus_if.done !== 1'b0 || bus_if.ovf !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset got res=%h busy=%b done=%b ovf=%b want all 0",
                     bus_if.matriz_resultante, bus_if.busy, bus_if.done, bus_if.ovf);
        end
        mat[7:0] = 8'd0;
        run_op(8'd2, mat, first, cnt);
        checks++;
        if (first !== 26 || cnt !== 1) begin
            errors++;
            $display("FAIL after_reset_done got first=%0d count=%0d want 26/1", first, cnt);
        end
        checks++;
        if (bus_if.matriz_resultante !== exp) begin
            errors++;
            $display("FAIL after_reset_result got %h want %h", bus_if.matriz_resultante, exp);
        end
        checks++;
        if (bus_if.ovf !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_ovf got %b want 0", bus_if.ovf);
        end
    endtask

    initial begin
        bus_if.start        = 1'b0;
        bus_if.abort        = 1'b0;
        bus_if.data_escalar = 8'h00;
        bus_if.matriz_a     = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
